bounce_generator: RTL

- Synthesizable mechanical-switch emulator: the clean-to-bouncy counterpart of the debouncer.
- When the clean request `target_in` changes, `bouncy_out` chatters for a pseudo-random (or fixed) number of toggles at pseudo-random (or fixed) intervals, then settles at the requested level.
- Drives debouncer inputs in benches and on-board self-test; an LFSR provides repeatable randomness.

---
 rtl/bounce_generator.sv | 119 +++++++++++
 1 files changed

// File: rtl/bounce_generator.sv
// ============================================================================
//  Module   : bounce_generator
//  Purpose  : Mechanical-switch emulator. A change on target_in produces a
//             burst of contact chatter before the output settles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bounce_generator #(
  parameter int          MIN_BOUNCES   = 2,
  parameter int          MAX_BOUNCES   = 12,
  parameter int          MAX_GAP_TICKS = 15,
  parameter int          FIXED_GAP     = 0,
  parameter int          SETTLE_TICKS  = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic target_in,
  output logic bouncy_out,
  output logic busy,
  output logic settled
);

  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_BOUNCE    = 2'd1;
  localparam logic [1:0]  S_SETTLE    = 2'd2;
  localparam logic [15:0] C_SEED      = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam int          C_SPAN      = MAX_BOUNCES - MIN_BOUNCES + 1;
  localparam logic [7:0]  C_SETTLE_M1 = 8'(SETTLE_TICKS - 1);

  logic [1:0]  r_state;
  logic [15:0] r_lfsr;
  logic [7:0]  r_remaining;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  r_settle_cnt;

  logic        w_fb;
  logic [7:0]  w_draw_n;
  logic [7:0]  w_draw_gap_m1;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  // Draws always use the current (pre-advance) LFSR value.
  generate
    if (MIN_BOUNCES == MAX_BOUNCES) begin : g_fixed_count
      assign w_draw_n = 8'(MIN_BOUNCES);
    end else begin : g_random_count
      assign w_draw_n = 8'(MIN_BOUNCES + (int'({24'd0, r_lfsr[7:0]}) % C_SPAN));
    end

    if (FIXED_GAP != 0) begin : g_fixed_gap
      assign w_draw_gap_m1 = 8'(FIXED_GAP - 1);
    end else begin : g_random_gap
      assign w_draw_gap_m1 = 8'(int'({24'd0, r_lfsr[15:8]}) % MAX_GAP_TICKS);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lfsr       <= C_SEED;
      r_remaining  <= 8'd0;
      r_gap_cnt    <= 8'd0;
      r_settle_cnt <= 8'd0;
      bouncy_out   <= 1'b0;
      busy         <= 1'b0;
      settled      <= 1'b0;
    end else begin
      // settled is a single-cycle pulse even while the enable is low.
      settled <= 1'b0;
      if (ena) begin
        r_lfsr <= {r_lfsr[14:0], w_fb};
        case (r_state)
          S_IDLE: begin
            if (target_in != bouncy_out) begin
              bouncy_out  <= ~bouncy_out;
              r_remaining <= w_draw_n;
              r_gap_cnt   <= w_draw_gap_m1;
              r_state     <= S_BOUNCE;
              busy        <= 1'b1;
            end
          end
          S_BOUNCE: begin
            if (r_gap_cnt != 8'd0) begin
              r_gap_cnt <= r_gap_cnt - 8'd1;
            end else if (r_remaining != 8'd0) begin
              bouncy_out  <= ~bouncy_out;
              r_remaining <= r_remaining - 8'd1;
              r_gap_cnt   <= w_draw_gap_m1;
            end else begin
              // Final level follows the latest request, not the one that started the burst.
              bouncy_out   <= target_in;
              r_settle_cnt <= C_SETTLE_M1;
              r_state      <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (r_settle_cnt != 8'd0) begin
              r_settle_cnt <= r_settle_cnt - 8'd1;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              settled <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
